lut_ram_fifo: RTL and testbench

//  16-entry first-word-fall-through FIFO whose storage is WIDTH RAM16X1D

---
 rtl/lut_ram_fifo.sv | 78 +++++++
 tb/tb_lut_ram_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lut_ram_fifo.sv
// 16-entry first-word-fall-through FIFO on distributed LUT RAM (one 16x1 dual-port cell per bit).
// Write port addressed by wr_ptr, asynchronous read port addressed by rd_ptr.
module lut_ram_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       count,
  output logic             almost_full
);

  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] count_q, count_d;
  logic       almost_full_q, almost_full_d;
  logic       push, pop, we;

  assign in_ready    = (count_q != 5'd16);
  assign out_valid   = (count_q != 5'd0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign we          = push & ~flush;
  assign count       = count_q;
  assign almost_full = almost_full_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 4'd0;
      rd_ptr_d = 4'd0;
      count_d  = 5'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 4'd1;
      if (pop)  rd_ptr_d = rd_ptr_q + 4'd1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
    end
    // Registered from next-count so the flag never lags count.
    almost_full_d = (count_d >= 5'(ALMOST_FULL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= 4'd0;
      rd_ptr_q      <= 4'd0;
      count_q       <= 5'd0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  // One 16x1 dual-port RAM per data bit; contents are deliberately not reset.
  for (genvar b = 0; b < int'(WIDTH); b++) begin : g_ram
    logic [15:0] mem;
    always_ff @(posedge clk) begin
      if (we) mem[wr_ptr_q] <= in_data[b];
    end
    assign out_data[b] = mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_lut_ram_fifo.sv
// Directed self-checking bench for lut_ram_fifo: fill, drain, push/pop, wrap, flush, async reset.
module tb_lut_ram_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       almost_full;

  int n_checks = 0;
  int n_errors = 0;

  lut_ram_fifo #(.WIDTH(8), .ALMOST_FULL(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Occupancy must stay within 0..16 at all times.
  always @(negedge clk) begin
    if (!reset) check("count_range", 32'(count <= 5'd16), 32'd1);
  end

  initial begin
    int mcount;
    int wi;
    int ri;
    int cyc;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    reset = 1'b0;
    step();

    // 1. Fill
    for (int i = 0; i < 16; i++) begin
      push_word(8'(i));
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_af", 32'(almost_full), 32'((i + 1) >= 12));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    push_word(8'h99);
    check("full_ignore_count", 32'(count), 32'd16);
    check("full_head", 32'(out_data), 32'h00);

    // 2. Drain
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_af", 32'(almost_full), 32'd0);

    // 3. Simultaneous push/pop at count=5, then at full
    for (int i = 0; i < 5; i++) push_word(8'(8'h50 + i));
    check("pp5_head", 32'(out_data), 32'h50);
    out_ready = 1'b1;
    push_word(8'hA5);
    out_ready = 1'b0;
    check("pp5_count", 32'(count), 32'd5);
    check("pp5_next_head", 32'(out_data), 32'h51);
    for (int i = 0; i < 11; i++) push_word(8'(8'h60 + i));
    check("pp16_count", 32'(count), 32'd16);
    out_ready = 1'b1;
    push_word(8'hEE);
    out_ready = 1'b0;
    check("pp16_count_after", 32'(count), 32'd15);
    check("pp16_in_ready", 32'(in_ready), 32'd1);
    check("pp16_head", 32'(out_data), 32'h52);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush1_count", 32'(count), 32'd0);

    // 4. Wrap-around stream with pseudo-random handshakes
    mcount = 0;
    wi = 0;
    ri = 0;
    cyc = 0;
    void'($urandom(32'd1234));
    while (ri < 40 && cyc < 2000) begin
      in_valid  = (wi < 40) && ($urandom_range(0, 3) != 0);
      in_data   = 8'(wi);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      check("wrap_count", 32'(count), 32'(mcount));
      check("wrap_in_ready", 32'(in_ready), 32'(mcount != 16));
      check("wrap_out_valid", 32'(out_valid), 32'(mcount != 0));
      if (out_valid && out_ready) begin
        check("wrap_data", 32'(out_data), 32'(ri));
        ri++;
        mcount--;
      end
      if (in_valid && in_ready) begin
        wi++;
        mcount++;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (ri < 40) check("wrap_timeout", 32'(ri), 32'd40);
    check("wrap_final_count", 32'(count), 32'd0);

    // 5. Flush with concurrent push at count=7
    for (int i = 0; i < 7; i++) push_word(8'(8'h70 + i));
    check("pre_flush_count", 32'(count), 32'd7);
    flush = 1'b1;
    push_word(8'hBB);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_af", 32'(almost_full), 32'd0);
    push_word(8'h3C);
    check("post_flush_valid", 32'(out_valid), 32'd1);
    check("post_flush_data", 32'(out_data), 32'h3C);
    check("post_flush_count", 32'(count), 32'd1);

    // 6. Async reset mid-cycle at count=9
    for (int i = 0; i < 8; i++) push_word(8'(i));
    check("pre_reset_count", 32'(count), 32'd9);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_count", 32'(count), 32'd0);
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_af", 32'(almost_full), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
    #1;
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
